// File: rtl/maq_bcd_modn.sv
// Two-digit BCD modulo-N counter with up/down count, clear, validated load,
// a registered wrap pulse and a combinational terminal-count output.
module maq_bcd_modn #(
    parameter int MODULO = 60,
    parameter int MSD_W  = 3
) (
    input  logic             maqs_clock,
    input  logic             maqs_reset,
    input  logic             maqs_clear,
    input  logic             maqs_enable,
    input  logic             maqs_up,
    input  logic             maqs_load,
    input  logic [3:0]       maqs_ld_lsd,
    input  logic [MSD_W-1:0] maqs_ld_msd,
    output logic [3:0]       maqs_Lsd,
    output logic [MSD_W-1:0] maqs_Msd,
    output logic             maqs_wrap,
    output logic             maqs_tc,
    output logic             maqs_load_err
);

    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'((MODULO - 1) / 10);
    localparam logic [3:0]       MAX_LSD = 4'((MODULO - 1) % 10);
    localparam logic [MSD_W-1:0] MSD_ONE = MSD_W'(1);

    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             wrap_q, wrap_d;
    logic             lerr_q, lerr_d;
    logic             at_max, at_zero, ld_ok;

    assign at_max  = (msd_q == MAX_MSD) && (lsd_q == MAX_LSD);
    assign at_zero = (msd_q == '0) && (lsd_q == 4'd0);

    // Tens digit below the top digit admits any units digit; at the top digit
    // the units digit is bounded by the terminal value.
    assign ld_ok = (maqs_ld_lsd <= 4'd9) &&
                   ((maqs_ld_msd < MAX_MSD) ||
                    ((maqs_ld_msd == MAX_MSD) && (maqs_ld_lsd <= MAX_LSD)));

    always_comb begin
        lsd_d  = lsd_q;
        msd_d  = msd_q;
        wrap_d = 1'b0;
        lerr_d = 1'b0;
        if (maqs_clear) begin
            lsd_d = 4'd0;
            msd_d = '0;
        end else if (maqs_load) begin
            if (ld_ok) begin
                lsd_d = maqs_ld_lsd;
                msd_d = maqs_ld_msd;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (maqs_enable) begin
            if (maqs_up) begin
                if (at_max) begin
                    lsd_d  = 4'd0;
                    msd_d  = '0;
                    wrap_d = 1'b1;
                end else if (lsd_q == 4'd9) begin
                    lsd_d = 4'd0;
                    msd_d = msd_q + MSD_ONE;
                end else begin
                    lsd_d = lsd_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    lsd_d  = MAX_LSD;
                    msd_d  = MAX_MSD;
                    wrap_d = 1'b1;
                end else if (lsd_q == 4'd0) begin
                    lsd_d = 4'd9;
                    msd_d = msd_q - MSD_ONE;
                end else begin
                    lsd_d = lsd_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge maqs_clock or negedge maqs_reset) begin
        if (!maqs_reset) begin
            lsd_q  <= 4'd0;
            msd_q  <= '0;
            wrap_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            lsd_q  <= lsd_d;
            msd_q  <= msd_d;
            wrap_q <= wrap_d;
            lerr_q <= lerr_d;
        end
    end

    assign maqs_Lsd      = lsd_q;
    assign maqs_Msd      = msd_q;
    assign maqs_wrap     = wrap_q;
    assign maqs_load_err = lerr_q;
    assign maqs_tc       = maqs_enable & (maqs_up ? at_max : at_zero);

endmodule
